// File: rtl/pixel_collector_if.sv
// Batch-in / pixel-out bundle between the engines, the collector and the pixel sink.
// The slave modport is the collector's view; master is the environment driving it.
interface pixel_collector_if #(
  parameter int PIXEL_DATA_WIDTH = 32,
  parameter int NUM_ENGINES      = 6
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        fin_flag;
  logic [PIXEL_DATA_WIDTH-1:0] in_data [NUM_ENGINES];
  logic [PIXEL_DATA_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_sof;
  logic                        out_eol;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, fin_flag, out_data, out_valid, out_sof, out_eol
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, fin_flag, out_data, out_valid, out_sof, out_eol
  );
endinterface

// File: rtl/pixel_collector.sv
// Captures one batch of engine results and serialises it as a raster-tagged pixel stream.
// Latency 1 cycle from capture to first pixel; one idle bubble per batch; out_ready stalls without loss.
module pixel_collector #(
  parameter int PIXEL_DATA_WIDTH = 32,
  parameter int SCREEN_WIDTH     = 1280,
  parameter int SCREEN_HEIGHT    = 720,
  parameter int NUM_ENGINES      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_collector_if.slave     io_pix
);
  localparam int IDX_W = (NUM_ENGINES   > 1) ? $clog2(NUM_ENGINES)   : 1;
  localparam int PX_W  = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
  localparam int PY_W  = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [PIXEL_DATA_WIDTH-1:0] r_buf [NUM_ENGINES];
  logic [IDX_W-1:0]            r_idx;
  logic [PX_W-1:0]             r_px;
  logic [PY_W-1:0]             r_py;

  logic w_in_ready;
  logic w_fin;
  logic w_out_valid;
  logic w_beat;
  logic w_last;
  logic w_px_wrap;
  logic w_py_wrap;

  assign w_last    = (r_idx == IDX_W'(NUM_ENGINES - 1));
  assign w_px_wrap = (r_px == PX_W'(SCREEN_WIDTH - 1));
  assign w_py_wrap = (r_py == PY_W'(SCREEN_HEIGHT - 1));
  assign w_fin     = io_pix.in_valid && w_in_ready;
  assign w_beat    = w_out_valid && io_pix.out_ready;

  // in_ready depends only on state and reset, never on out_ready.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = !reset;
        if (io_pix.in_valid && !reset) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_out_valid = 1'b1;
        if (io_pix.out_ready && w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_fin) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        r_buf[i] <= io_pix.in_data[i];
      end
    end
  end

  // idx parks on the last entry after draining, so out_data keeps the last buffer word in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_fin) begin
      r_idx <= '0;
    end else if (w_beat && !w_last) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Raster position runs freely across batch boundaries, matching the distributor's wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_px <= '0;
      r_py <= '0;
    end else if (w_beat) begin
      if (w_px_wrap) begin
        r_px <= '0;
        r_py <= w_py_wrap ? '0 : r_py + PY_W'(1);
      end else begin
        r_px <= r_px + PX_W'(1);
      end
    end
  end

  assign io_pix.in_ready  = w_in_ready;
  assign io_pix.fin_flag  = w_fin;
  assign io_pix.out_valid = w_out_valid;
  assign io_pix.out_data  = r_buf[r_idx];
  assign io_pix.out_sof   = w_out_valid && (r_px == '0) && (r_py == '0);
  assign io_pix.out_eol   = w_out_valid && w_px_wrap;
endmodule

// File: tb/tb_pixel_collector.sv
// Bench for pixel_collector at small parameters: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_pixel_collector;
  localparam int W  = 8;
  localparam int H  = 2;
  localparam int N  = 3;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_collector_if #(.PIXEL_DATA_WIDTH(DW), .NUM_ENGINES(N)) bus();

  pixel_collector #(
    .PIXEL_DATA_WIDTH(DW),
    .SCREEN_WIDTH    (W),
    .SCREEN_HEIGHT   (H),
    .NUM_ENGINES     (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_pix(bus)
  );

  typedef struct {
    logic [DW-1:0] d;
    bit            sof;
    bit            eol;
  } pix_t;

  pix_t m_q[$];
  pix_t beat_log[$];
  int   m_n     = 0;
  bit   m_fresh = 1'b1;
  int   fin_cnt = 0;
  int   checks  = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a pixel queue filled on capture, tags computed from the running pixel number.
  bit m_rdy, m_fin, m_vld;
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_fin", 32'(bus.fin_flag), 0);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_sof", 32'(bus.out_sof), 0);
      chk("rst_eol", 32'(bus.out_eol), 0);
      chk("rst_data", 32'(bus.out_data), 0);
      m_q.delete();
      m_n     = 0;
      m_fresh = 1'b1;
    end else begin
      m_rdy = (m_q.size() == 0);
      m_fin = bus.in_valid && m_rdy;
      m_vld = (m_q.size() != 0);
      chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
      chk("fin_flag", 32'(bus.fin_flag), 32'(m_fin));
      chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
      if (m_vld) begin
        chk("out_data", 32'(bus.out_data), 32'(m_q[0].d));
        chk("out_sof", 32'(bus.out_sof), 32'(m_q[0].sof));
        chk("out_eol", 32'(bus.out_eol), 32'(m_q[0].eol));
        if (bus.out_ready) begin
          beat_log.push_back(m_q[0]);
          void'(m_q.pop_front());
        end
      end else begin
        chk("idle_sof", 32'(bus.out_sof), 0);
        chk("idle_eol", 32'(bus.out_eol), 0);
        if (m_fresh) chk("idle_data", 32'(bus.out_data), 0);
      end
      if (m_fin) begin
        fin_cnt++;
        m_fresh = 1'b0;
        for (int i = 0; i < N; i++) begin
          pix_t p;
          p.d   = bus.in_data[i];
          p.sof = (m_n % (W * H)) == 0;
          p.eol = (m_n % W) == (W - 1);
          m_q.push_back(p);
          m_n++;
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.in_ready !== 1'b1 && k < 50);
    chk(name, 32'(bus.in_ready), 1);
  endtask

  task automatic wait_fin(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.fin_flag !== 1'b1 && k < 20);
    chk(name, 32'(bus.fin_flag), 1);
  endtask

  task automatic set_batch(input int base);
    for (int i = 0; i < N; i++) bus.in_data[i] = 8'(base + i);
  endtask

  int f0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_batch(0);

    // Reset values
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out_data", 32'(bus.out_data), 0);
    chk("reset_fin", 32'(bus.fin_flag), 0);

    // Single batch
    f0 = fin_cnt;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    set_batch(8'h10);
    @(negedge clk);
    chk("single_fin", 32'(bus.fin_flag), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("single_valid", 32'(bus.out_valid), 1);
      chk("single_data", 32'(bus.out_data), 32'(8'h10 + i));
      chk("single_sof", 32'(bus.out_sof), 32'(i == 0));
      chk("single_in_ready_low", 32'(bus.in_ready), 0);
    end
    @(negedge clk);
    chk("single_in_ready_back", 32'(bus.in_ready), 1);
    chk("single_valid_done", 32'(bus.out_valid), 0);
    chk("single_fin_pulses", 32'(fin_cnt - f0), 1);

    // Backpressure: sink stalls 5 cycles, in_valid stays high and data changes underneath
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_batch(8'h20);
    @(negedge clk);
    chk("bp_fin", 32'(bus.fin_flag), 1);
    @(posedge clk); #1;
    bus.in_data[0] = 8'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_data", 32'(bus.out_data), 32'h20);
      chk("bp_fin_low", 32'(bus.fin_flag), 0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("bp_drain");
    chk("bp_log0", 32'(beat_log[beat_log.size() - 3].d), 32'h20);
    chk("bp_log1", 32'(beat_log[beat_log.size() - 2].d), 32'h21);
    chk("bp_log2", 32'(beat_log[beat_log.size() - 1].d), 32'h22);

    // Line and frame straddle: 6 back-to-back batches from (0,0)
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    beat_log.delete();
    f0 = fin_cnt;
    bus.in_valid = 1'b1;
    for (int b = 0; b < 6; b++) begin
      set_batch(b * N);
      wait_fin("straddle_fin");
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_idle("straddle_drain");
    chk("straddle_beats", 32'(beat_log.size()), 18);
    chk("straddle_fins", 32'(fin_cnt - f0), 6);
    for (int j = 0; j < 18 && j < beat_log.size(); j++) begin
      chk("straddle_data", 32'(beat_log[j].d), 32'(j));
      chk("straddle_sof", 32'(beat_log[j].sof), 32'(j == 0 || j == 16));
      chk("straddle_eol", 32'(beat_log[j].eol), 32'(j == 7 || j == 15));
    end

    // Reset after one beat of a batch
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    set_batch(8'h30);
    @(negedge clk);
    chk("midrst_fin", 32'(bus.fin_flag), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_beat_data", 32'(bus.out_data), 32'h30);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_data", 32'(bus.out_data), 0);
    @(posedge clk); #1 reset = 1'b0;
    bus.in_valid = 1'b1;
    set_batch(8'h40);
    @(negedge clk);
    chk("midrst_refin", 32'(bus.fin_flag), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_first_data", 32'(bus.out_data), 32'h40);
    chk("midrst_first_sof", 32'(bus.out_sof), 1);
    wait_idle("midrst_drain");

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset         = ($urandom_range(0, 299) == 0);
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) bus.in_data[i] = 8'($urandom);
    end
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
